// File: rtl/wb_forward_source_pkg.sv
// Shared definitions for the writeback/forwarding stage: opcodes, load funct3
// encodings and the writeback state enum.
package wb_forward_source_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_COMMIT    = 2'd1,
        WB_LOAD_WAIT = 2'd2,
        WB_LOAD_DONE = 2'd3
    } wb_state_e;

    // A destination exists unless the opcode never writes or rd is x0.
    function automatic logic writes_rd(input logic [6:0] opcode, input logic [4:0] rd);
        return !((opcode == OPC_BRANCH) || (opcode == OPC_STORE)) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/wb_forward_source_load_extend.sv
// Combinational load lane select and sign/zero extension keyed on funct3 and
// the low address bits.
module wb_forward_source_load_extend
    import wb_forward_source_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [31:0]     rdata,
    output logic [XLEN-1:0] ext_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[8*addr +: 8];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        ext_data  = '0;
        case (funct3)
            F3_LB:   ext_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   ext_data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_lane};
            F3_LW:   ext_data = XLEN'(rdata);
            default: ext_data = '0;
        endcase
    end

endmodule

// File: rtl/wb_forward_source.sv
// Stage-3 writeback register and forwarding source; holds loads until memory
// data arrives. Optional load watchdog enabled by defining LOAD_TIMEOUT_EN.
module wb_forward_source
    import wb_forward_source_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [31:0]     ex_inst,
    input  logic [31:0]     ex_pc,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [31:0]     dmem_rdata,
    input  logic            dmem_rvalid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fwd_valid,
    output logic            fwd_pending,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            load_timeout
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 4-bit wait counter (1..15)");
    end

    wb_state_e       state_q, state_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [31:0]     pc_q, pc_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic            accept;
    logic            has_rd;
    logic            drop_write;
    logic [XLEN-1:0] ext_data;
    logic            unused_inst;

    // Only the decode fields this stage needs are kept.
    assign unused_inst = ^ex_inst[31:15];
    assign has_rd      = writes_rd(opcode_q, rd_q);
    assign accept      = ex_valid && ex_ready;

    wb_forward_source_load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3   (funct3_q),
        .addr     (result_q[1:0]),
        .rdata    (dmem_rdata),
        .ext_data (ext_data)
    );

`ifdef LOAD_TIMEOUT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       timed_out_q, timed_out_d;

    assign load_timeout = timeout_q;
    assign drop_write   = timed_out_q;
`else
    assign load_timeout = 1'b0;
    assign drop_write   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        pc_d        = pc_q;
        result_d    = result_q;
        load_data_d = load_data_q;
`ifdef LOAD_TIMEOUT_EN
        wait_cnt_d  = 4'd0;
        timeout_d   = timeout_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            WB_LOAD_WAIT: begin
                if (dmem_rvalid) begin
                    load_data_d = ext_data;
                    state_d     = WB_LOAD_DONE;
                end
`ifdef LOAD_TIMEOUT_EN
                else if (wait_cnt_q == 4'(TIMEOUT_CYCLES - 1)) begin
                    load_data_d = '0;
                    timeout_d   = 1'b1;
                    timed_out_d = 1'b1;
                    state_d     = WB_LOAD_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
`endif
            end
            default: begin
                if (accept) begin
                    opcode_d = ex_inst[6:0];
                    rd_d     = ex_inst[11:7];
                    funct3_d = ex_inst[14:12];
                    pc_d     = ex_pc;
                    result_d = ex_alu_result;
                    state_d  = (ex_inst[6:0] == OPC_LOAD) ? WB_LOAD_WAIT : WB_COMMIT;
`ifdef LOAD_TIMEOUT_EN
                    timed_out_d = 1'b0;
`endif
                end else begin
                    state_d = WB_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ex_ready    = (state_q != WB_LOAD_WAIT);
        wb_we       = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = '0;
        fwd_valid   = 1'b0;
        fwd_pending = 1'b0;
        fwd_rd      = 5'd0;
        case (state_q)
            WB_COMMIT: begin
                wb_we     = has_rd;
                fwd_valid = has_rd;
                wb_rd     = rd_q;
                fwd_rd    = rd_q;
                wb_data   = ((opcode_q == OPC_JAL) || (opcode_q == OPC_JALR))
                            ? XLEN'(pc_q + 32'd4) : result_q;
            end
            WB_LOAD_WAIT: begin
                fwd_pending = has_rd;
                fwd_rd      = rd_q;
            end
            WB_LOAD_DONE: begin
                wb_we     = has_rd && !drop_write;
                fwd_valid = has_rd && !drop_write;
                wb_rd     = rd_q;
                fwd_rd    = rd_q;
                wb_data   = load_data_q;
            end
            default: ;
        endcase
        fwd_data = wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WB_IDLE;
            opcode_q    <= 7'd0;
            rd_q        <= 5'd0;
            funct3_q    <= 3'd0;
            pc_q        <= 32'd0;
            result_q    <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            pc_q        <= pc_d;
            result_q    <= result_d;
            load_data_q <= load_data_d;
        end
    end

`ifdef LOAD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= 4'd0;
            timeout_q   <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            timed_out_q <= timed_out_d;
        end
    end
`endif

endmodule
